keypad_digit_entry: RTL and testbench
=====================================

Name: keypad_digit_entry

Overview:
- Sequential, parametrised successor to the combinational decimal-to-BCD key encoder in the microwave front panel.
- Synchronises and debounces a one-hot keypad and encodes the pressed key to BCD.
- Emits one pulse per accepted press and shifts accepted digits into a multi-digit entry register, which feeds the cook-time loader and display.

Parameters:
- NUM_KEYS, 10: keypad lines, legal range 2..10; key i encodes to BCD value i.
- DEBOUNCE_CYCLES, 4: consecutive stable samples required to accept a press and to accept a release; minimum 1.
- NUM_DIGITS, 4: BCD digits held in the entry register.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  active-low enable, same polarity as the existing encoder.
- KEYS  in  NUM_KEYS  raw, asynchronous, one-hot keypad lines.
- CLEAR  in  1  synchronous clear of the entry register.
- KEY_BCD  out  4  BCD code of the last accepted key.
- KEY_VALID  out  1  one-cycle pulse per accepted press.
- DIGITS  out  4*NUM_DIGITS  entry register; newest digit in [3:0], oldest in the top nibble.
- DIGIT_COUNT  out  $clog2(NUM_DIGITS+1)  number of digits entered.
- FULL  out  1  high when DIGIT_COUNT == NUM_DIGITS.
- OVERFLOW  out  1  one-cycle pulse when a press is accepted while FULL.

Behaviour:
- Reset (RST_N low, asynchronous): every output is 0, FSM is IDLE, synchroniser and counters are cleared.
- Synchroniser: KEYS passes through 2 flops to give key_s. The FSM uses only key_s.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- IDLE:
  - key_s one-hot: latch the pattern, set cnt=1, go to DEBOUNCE.
  - key_s zero or multi-hot: stay in IDLE.
- DEBOUNCE:
  - key_s equal to the latched pattern: cnt++.
  - When cnt reaches DEBOUNCE_CYCLES: go to HELD and register the accept event.
  - Any mismatch (change, multi-hot or zero): back to IDLE, no output.
- Accept event, at the same edge as the DEBOUNCE-to-HELD transition:
  - KEY_BCD is set to the latched key index.
  - KEY_VALID is high for exactly one cycle.
  - Entry register:
    - If not FULL: DIGITS shifts left by 4 with the new digit in [3:0], and DIGIT_COUNT++.
    - If FULL: DIGITS and DIGIT_COUNT are unchanged and OVERFLOW pulses together with KEY_VALID.
- HELD:
  - key_s zero: go to RELEASE with cnt=1.
  - Any other value, including a change to another key or multi-hot: stay in HELD. No second accept without a release.
- RELEASE:
  - key_s zero: cnt++; when cnt reaches DEBOUNCE_CYCLES, go to IDLE.
  - Any nonzero: back to HELD (bounce on release).
- Latency: with KEYS held steady one-hot before edge 0, KEY_VALID is high in the cycle after edge DEBOUNCE_CYCLES+2 (2 sync edges plus DEBOUNCE_CYCLES debounce samples).
- CLEAR, synchronous:
  - Zeroes DIGITS and DIGIT_COUNT. KEY_BCD and the FSM are unaffected.
  - CLEAR coincident with an accept event: CLEAR wins. The digit is discarded, KEY_VALID still pulses, OVERFLOW is not asserted.
- EN high (disabled):
  - FSM is forced to IDLE and cnt to 0. KEY_VALID and OVERFLOW are held 0.
  - DIGITS, DIGIT_COUNT and KEY_BCD keep their values. CLEAR stays functional.
  - Re-enabling requires a full new debounce; a key held across re-enable is accepted once.
- Reset mid-debounce or mid-hold: immediate return to reset values, no pulse.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). It saturates and never wraps.

Decomposition:
- Package keypad_pkg:
  - FSM state enum (IDLE, DEBOUNCE, HELD, RELEASE), 2 bits.
  - BCD_W=4.
  - Function onehot_to_bcd: returns the index and an is_onehot flag.
- One natural sub-module: sync_2ff, parametrised width, reused by other panel inputs.
- FSM and entry register stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, NUM_DIGITS=4):
- Reset: hold KEYS=10'b0000001000 and pulse RST_N low -> all outputs 0. Release reset with the key still held -> one KEY_VALID with KEY_BCD=3 at edge 6 after KEYS became steady, DIGITS=16'h0003, DIGIT_COUNT=1.
- Bounce: key 5 toggled 1-0-1 with 2-cycle pulses, then held steady -> only one KEY_VALID (KEY_BCD=5). Bounce on release -> no extra pulse.
- Entry and overflow: press 1,2,0,5 then 9 -> DIGITS=16'h1205, FULL=1. The 5th press gives KEY_VALID, OVERFLOW=1, DIGITS unchanged.
- Multi-hot: KEYS=10'b0000000110 held 20 cycles -> no KEY_VALID, FSM stays in IDLE.
- CLEAR coincident with the accept of key 7 on a register holding 3 digits -> DIGITS=0, DIGIT_COUNT=0, KEY_VALID=1, KEY_BCD=7, OVERFLOW=0.
- EN=1 during a debounce of key 4 -> no pulse and DIGITS retained. EN=0 with the key still held -> exactly one accept, 4 debounce cycles later.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and key decoding for the front-panel keypad logic.
package keypad_pkg;
    localparam int BCD_W = 4;
    localparam int MAX_KEYS = 10;
    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
    typedef struct packed {
        logic [BCD_W-1:0] bcd;
        logic             is_onehot;
    } key_code_t;
    function automatic key_code_t onehot_to_bcd(input logic [MAX_KEYS-1:0] k);
        key_code_t r;
        r.bcd = '0;
        r.is_onehot = (k != '0) && ((k & (k - MAX_KEYS'(1))) == '0);
        for (int i = 0; i < MAX_KEYS; i++)
            if (k[i]) r.bcd = BCD_W'(i);
        return r;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous panel inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= '0;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_digit_entry.sv
// keypad_digit_entry: debounces a one-hot keypad, encodes presses to BCD and
// shifts accepted digits into a multi-digit entry register.
module keypad_digit_entry
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS        = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NUM_DIGITS      = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [NUM_KEYS-1:0]              keys,
    input  logic                             clear,
    output logic [BCD_W-1:0]                 key_bcd,
    output logic                             key_valid,
    output logic [BCD_W*NUM_DIGITS-1:0]      digits,
    output logic [$clog2(NUM_DIGITS+1)-1:0]  digit_count,
    output logic                             full,
    output logic                             overflow
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES+1);
    localparam int DW = $clog2(NUM_DIGITS+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] COUNT_MAX = DW'(NUM_DIGITS);

    logic [NUM_KEYS-1:0] key_s, pat, pat_nx;
    logic [BCD_W-1:0]    idx, idx_nx;
    logic [CW-1:0]       cnt, cnt_nx, cnt_inc;
    state_t              state, state_nx;
    key_code_t           code_s;
    logic                accept;

    sync_2ff #(.WIDTH(NUM_KEYS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (keys),
        .q     (key_s)
    );

    assign code_s  = onehot_to_bcd(MAX_KEYS'(key_s));
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign full    = digit_count == COUNT_MAX;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pat   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pat   <= pat_nx;
            idx   <= idx_nx;
        end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pat_nx   = pat;
        idx_nx   = idx;
        if (en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE:
                    if (code_s.is_onehot) begin
                        state_nx = DEBOUNCE;
                        cnt_nx   = CW'(1);
                        pat_nx   = key_s;
                        idx_nx   = code_s.bcd;
                    end
                DEBOUNCE:
                    if (key_s != pat) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_MAX) state_nx = HELD;
                    else cnt_nx = cnt_inc;
                HELD:
                    if (key_s == '0) begin
                        state_nx = RELEASE;
                        cnt_nx   = CW'(1);
                    end
                RELEASE:
                    if (key_s != '0) state_nx = HELD;
                    else if (cnt == CNT_MAX) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else cnt_nx = cnt_inc;
                default: state_nx = IDLE;
            endcase
        end
    end

    // accept fires on the sample that completes the debounce and moves DEBOUNCE to HELD
    always_comb accept = !en && state == DEBOUNCE && key_s == pat && cnt == CNT_MAX;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            key_valid   <= 1'b0;
            overflow    <= 1'b0;
            key_bcd     <= '0;
            digits      <= '0;
            digit_count <= '0;
        end else begin
            key_valid <= accept;
            overflow  <= accept && full && !clear;
            if (accept) key_bcd <= idx;
            if (clear) begin
                digits      <= '0;
                digit_count <= '0;
            end else if (accept && !full) begin
                digits      <= (digits << BCD_W) | (BCD_W*NUM_DIGITS)'(idx);
                digit_count <= digit_count + DW'(1);
            end
        end
endmodule

// File: tb/tb_keypad_digit_entry.sv
// tb_keypad_digit_entry: randomized self-checking bench with a digit-queue reference model.
module tb_keypad_digit_entry;
    import keypad_pkg::*;
    localparam int NK = 10;
    localparam int D  = 4;
    localparam int ND = 4;

    logic          clk = 0, rst_n = 0, en = 0, clear = 0;
    logic [NK-1:0] keys = '0;
    logic [3:0]    key_bcd;
    logic          key_valid, full, overflow;
    logic [15:0]   digits;
    logic [2:0]    digit_count;

    int passed = 0, total = 0;
    int n_valid, first_valid, n_ovf, edge_i;
    logic [3:0] seen_bcd;
    int mq[$];

    keypad_digit_entry #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .NUM_DIGITS(ND)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .keys        (keys),
        .clear       (clear),
        .key_bcd     (key_bcd),
        .key_valid   (key_valid),
        .digits      (digits),
        .digit_count (digit_count),
        .full        (full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_digits();
        logic [15:0] v = '0;
        foreach (mq[i]) v = (v << 4) | 16'(mq[i]);
        return v;
    endfunction

    function automatic void model_accept(int k, bit clr);
        if (clr) mq.delete();
        else if (mq.size() < ND) mq.push_back(k);
    endfunction

    task automatic clr_stats();
        n_valid = 0; first_valid = -1; n_ovf = 0; edge_i = 0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (key_valid) begin
                if (n_valid == 0) first_valid = edge_i;
                n_valid++;
                seen_bcd = key_bcd;
            end
            if (overflow) n_ovf++;
            edge_i++;
        end
    endtask

    task automatic press(int k, int hold, int rel);
        keys = NK'(1) << k;
        run(hold);
        keys = '0;
        run(rel);
    endtask

    task automatic pulse_clear();
        clear = 1;
        run(1);
        clear = 0;
        mq.delete();
    endtask

    task automatic test_reset();
        keys = NK'(1) << 3;
        clr_stats();
        run(3);
        total++;
        if ({key_bcd, key_valid, digits, digit_count, full, overflow} !== '0)
            $display("FAIL reset_outputs: got bcd=%h v=%b dig=%h cnt=%0d full=%b ovf=%b want all 0",
                     key_bcd, key_valid, digits, digit_count, full, overflow);
        else passed++;
        rst_n = 1;
        clr_stats();
        run(12);
        model_accept(3, 0);
        total++;
        if (first_valid !== 6 || n_valid !== 1)
            $display("FAIL reset_latency: got first=%0d n=%0d want first=6 n=1", first_valid, n_valid);
        else passed++;
        total++;
        if (seen_bcd !== 4'd3) $display("FAIL reset_bcd: got %0d want 3", seen_bcd);
        else passed++;
        total++;
        if (digits !== model_digits() || digit_count !== 3'(mq.size()))
            $display("FAIL reset_entry: got %h/%0d want %h/%0d", digits, digit_count, model_digits(), mq.size());
        else passed++;
        keys = '0;
        run(10);
    endtask

    task automatic test_reset_mid_debounce();
        keys = NK'(1) << 2;
        clr_stats();
        run(4);
        rst_n = 0;
        #1;
        mq.delete();
        total++;
        if ({key_bcd, key_valid, digits, digit_count} !== '0)
            $display("FAIL reset_mid: got bcd=%h v=%b dig=%h cnt=%0d want all 0", key_bcd, key_valid, digits, digit_count);
        else passed++;
        run(2);
        keys = '0;
        rst_n = 1;
        run(12);
        total++;
        if (n_valid !== 0) $display("FAIL reset_mid_pulse: got %0d pulses want 0", n_valid);
        else passed++;
    endtask

    task automatic test_bounce();
        clr_stats();
        for (int i = 0; i < 2; i++) begin
            keys = NK'(1) << 5; run(2);
            keys = '0;          run(2);
        end
        keys = NK'(1) << 5; run(10);
        keys = '0;          run(2);
        keys = NK'(1) << 5; run(2);
        keys = '0;          run(12);
        model_accept(5, 0);
        total++;
        if (n_valid !== 1 || seen_bcd !== 4'd5)
            $display("FAIL bounce: got n=%0d bcd=%0d want n=1 bcd=5", n_valid, seen_bcd);
        else passed++;
        total++;
        if (digits !== model_digits())
            $display("FAIL bounce_entry: got %h want %h", digits, model_digits());
        else passed++;
    endtask

    task automatic test_entry_overflow();
        int seq[4] = '{1, 2, 0, 5};
        pulse_clear();
        foreach (seq[i]) begin
            press(seq[i], $urandom_range(8, 14), $urandom_range(8, 12));
            model_accept(seq[i], 0);
        end
        total++;
        if (digits !== 16'h1205 || digits !== model_digits() || full !== 1'b1)
            $display("FAIL entry_full: got %h full=%b want 1205 full=1", digits, full);
        else passed++;
        clr_stats();
        press(9, 10, 10);
        model_accept(9, 0);
        total++;
        if (n_valid !== 1 || n_ovf !== 1 || seen_bcd !== 4'd9)
            $display("FAIL overflow_pulse: got n=%0d ovf=%0d bcd=%0d want 1/1/9", n_valid, n_ovf, seen_bcd);
        else passed++;
        total++;
        if (digits !== model_digits() || digit_count !== 3'd4)
            $display("FAIL overflow_entry: got %h/%0d want %h/4", digits, digit_count, model_digits());
        else passed++;
    endtask

    task automatic test_multi_hot();
        int bad = 0;
        clr_stats();
        keys = NK'(6);
        for (int i = 0; i < 20; i++) begin
            run(1);
            if (dut.state !== IDLE) bad++;
        end
        keys = '0;
        run(4);
        total++;
        if (n_valid !== 0 || bad !== 0)
            $display("FAIL multi_hot: got pulses=%0d non_idle=%0d want 0/0", n_valid, bad);
        else passed++;
    endtask

    task automatic test_clear_coincident();
        pulse_clear();
        for (int i = 0; i < 3; i++) begin
            int k = $urandom_range(0, 9);
            press(k, 9, 9);
            model_accept(k, 0);
        end
        total++;
        if (digit_count !== 3'd3) $display("FAIL clr_pre_count: got %0d want 3", digit_count);
        else passed++;
        keys = NK'(1) << 7;
        run(6);
        clear = 1;
        run(1);
        model_accept(7, 1);
        total++;
        if (key_valid !== 1'b1 || key_bcd !== 4'd7 || overflow !== 1'b0)
            $display("FAIL clr_accept: got v=%b bcd=%0d ovf=%b want 1/7/0", key_valid, key_bcd, overflow);
        else passed++;
        total++;
        if (digits !== model_digits() || digit_count !== 3'd0)
            $display("FAIL clr_entry: got %h/%0d want %h/0", digits, digit_count, model_digits());
        else passed++;
        clear = 0;
        keys = '0;
        run(12);
    endtask

    task automatic test_enable();
        press(2, 9, 9);
        model_accept(2, 0);
        keys = NK'(1) << 4;
        run(4);
        en = 1;
        clr_stats();
        run(8);
        total++;
        if (n_valid !== 0 || digits !== model_digits() || key_bcd !== 4'd2)
            $display("FAIL en_hold: got n=%0d dig=%h bcd=%0d want 0/%h/2", n_valid, digits, key_bcd, model_digits());
        else passed++;
        pulse_clear();
        total++;
        if (digits !== 16'h0 || digit_count !== 3'd0)
            $display("FAIL en_clear: got %h/%0d want 0/0", digits, digit_count);
        else passed++;
        en = 0;
        clr_stats();
        run(12);
        model_accept(4, 0);
        total++;
        if (first_valid !== 4 || n_valid !== 1 || seen_bcd !== 4'd4)
            $display("FAIL en_reaccept: got first=%0d n=%0d bcd=%0d want 4/1/4", first_valid, n_valid, seen_bcd);
        else passed++;
        total++;
        if (digits !== model_digits()) $display("FAIL en_entry: got %h want %h", digits, model_digits());
        else passed++;
        keys = '0;
        run(12);
    endtask

    task automatic test_random_entry();
        for (int n = 0; n < 14; n++) begin
            int k = $urandom_range(0, 9);
            bit exp_ovf;
            if ($urandom_range(0, 5) == 0) pulse_clear();
            exp_ovf = mq.size() == ND;
            clr_stats();
            press(k, $urandom_range(8, 14), $urandom_range(8, 12));
            model_accept(k, 0);
            total++;
            if (n_valid !== 1 || first_valid !== 6 || seen_bcd !== 4'(k) || n_ovf !== int'(exp_ovf))
                $display("FAIL rand_press: got n=%0d first=%0d bcd=%0d ovf=%0d want 1/6/%0d/%0d",
                         n_valid, first_valid, seen_bcd, n_ovf, k, exp_ovf);
            else passed++;
            total++;
            if (digits !== model_digits() || digit_count !== 3'(mq.size()) || full !== (mq.size() == ND))
                $display("FAIL rand_entry: got %h/%0d full=%b want %h/%0d", digits, digit_count, full,
                         model_digits(), mq.size());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_debounce();
        test_bounce();
        test_entry_overflow();
        test_multi_hot();
        test_clear_coincident();
        test_enable();
        test_random_entry();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
